// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths and requester indices for the ROB writeback port arbiter.
package wb_port_arbiter_pkg;

    localparam int WB_WORD_SIZE       = 32;
    localparam int WB_INSTR_TYPE_SZ   = 4;
    localparam int WB_ROB_ENTRY_WIDTH = 6;
    localparam int WB_NUM_REQ         = 3;
    localparam int WB_WAIT_CNT_W      = 8;

    localparam int WB_REQ_ALU = 0;
    localparam int WB_REQ_MEM = 1;
    localparam int WB_REQ_MUL = 2;

    function automatic int wrap_inc(input int idx, input int num);
        return (idx + 1) % num;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the execution pipes / ROB (master) and the writeback arbiter (slave).
interface wb_port_arbiter_if #(
    parameter int NUM_REQ         = 3,
    parameter int WORD_SIZE       = 32,
    parameter int INSTR_TYPE_SZ   = 4,
    parameter int ROB_ENTRY_WIDTH = 6,
    parameter int WAIT_CNT_W      = 8
);
    logic [NUM_REQ-1:0]                 req_valid;
    logic [NUM_REQ*INSTR_TYPE_SZ-1:0]   req_instr_type;
    logic [NUM_REQ*WORD_SIZE-1:0]       req_pc;
    logic [NUM_REQ*WORD_SIZE-1:0]       req_result;
    logic [NUM_REQ*ROB_ENTRY_WIDTH-1:0] req_rob_id;
    logic                               rob_ready;
    logic                               flush;
    logic [NUM_REQ-1:0]                 req_stall;
    logic [NUM_REQ-1:0]                 grant;
    logic                               wb_valid;
    logic [INSTR_TYPE_SZ-1:0]           wb_instr_type;
    logic [WORD_SIZE-1:0]               wb_pc;
    logic [WORD_SIZE-1:0]               wb_result;
    logic [ROB_ENTRY_WIDTH-1:0]         wb_rob_id;
    logic [NUM_REQ*WAIT_CNT_W-1:0]      wait_cnt;

    modport master (
        output req_valid, req_instr_type, req_pc, req_result, req_rob_id, rob_ready, flush,
        input  req_stall, grant, wb_valid, wb_instr_type, wb_pc, wb_result, wb_rob_id, wait_cnt
    );

    modport slave (
        input  req_valid, req_instr_type, req_pc, req_result, req_rob_id, rob_ready, flush,
        output req_stall, grant, wb_valid, wb_instr_type, wb_pc, wb_result, wb_rob_id, wait_cnt
    );
endinterface

// File: rtl/wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or above the pointer, else lowest overall.
module wb_port_arbiter_rr_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_next_ptr
);
    logic [NUM_REQ-1:0] w_upper;
    logic               w_found;

    always_comb begin
        // NOTE: every output gets a default before any branch, so no latch can be inferred.
        o_grant    = '0;
        o_next_ptr = i_ptr;
        w_found    = 1'b0;
        w_upper    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_upper[i] = i_req[i] && (i >= int'(i_ptr));
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_upper[i]) begin
                w_found    = 1'b1;
                o_grant[i] = 1'b1;
                o_next_ptr = PTR_W'(wrap_inc(i, NUM_REQ));
            end
        end
        // Nothing at or above the pointer: wrap around to the lowest requester.
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && i_req[i]) begin
                w_found    = 1'b1;
                o_grant[i] = 1'b1;
                o_next_ptr = PTR_W'(wrap_inc(i, NUM_REQ));
            end
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single ROB writeback port among NUM_REQ pipes with round-robin arbitration.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ         = WB_NUM_REQ,
    parameter int WORD_SIZE       = WB_WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = WB_INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WIDTH = WB_ROB_ENTRY_WIDTH,
    parameter int WAIT_CNT_W      = WB_WAIT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]                        r_rr_ptr;
    logic [PTR_W-1:0]                        w_next_ptr;
    logic                                    w_arb_en;
    logic [NUM_REQ-1:0]                      w_req;
    logic [NUM_REQ-1:0]                      w_grant;
    logic [NUM_REQ-1:0]                      w_stall;
    logic [INSTR_TYPE_SZ-1:0]                w_sel_instr_type;
    logic [WORD_SIZE-1:0]                    w_sel_pc;
    logic [WORD_SIZE-1:0]                    w_sel_result;
    logic [ROB_ENTRY_WIDTH-1:0]              w_sel_rob_id;
    logic                                    r_wb_valid;
    logic [INSTR_TYPE_SZ-1:0]                r_wb_instr_type;
    logic [WORD_SIZE-1:0]                    r_wb_pc;
    logic [WORD_SIZE-1:0]                    r_wb_result;
    logic [ROB_ENTRY_WIDTH-1:0]              r_wb_rob_id;
    logic [NUM_REQ-1:0][WAIT_CNT_W-1:0]      r_wait_cnt;

    // Reset is folded in so grant and stall drop asynchronously with it.
    assign w_arb_en = reset & bus.rob_ready & ~bus.flush;
    assign w_req    = bus.req_valid & {NUM_REQ{w_arb_en}};
    assign w_stall  = bus.req_valid & ~w_grant & {NUM_REQ{reset & ~bus.flush}};

    wb_port_arbiter_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .i_req      (w_req),
        .i_ptr      (r_rr_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    always_comb begin
        w_sel_instr_type = '0;
        w_sel_pc         = '0;
        w_sel_result     = '0;
        w_sel_rob_id     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_instr_type = bus.req_instr_type[i*INSTR_TYPE_SZ +: INSTR_TYPE_SZ];
                w_sel_pc         = bus.req_pc[i*WORD_SIZE +: WORD_SIZE];
                w_sel_result     = bus.req_result[i*WORD_SIZE +: WORD_SIZE];
                w_sel_rob_id     = bus.req_rob_id[i*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr        <= '0;
            r_wb_valid      <= 1'b0;
            r_wb_instr_type <= '0;
            r_wb_pc         <= '0;
            r_wb_result     <= '0;
            r_wb_rob_id     <= '0;
        end else begin
            r_wb_valid <= |w_grant;
            if (|w_grant) begin
                r_rr_ptr        <= w_next_ptr;
                r_wb_instr_type <= w_sel_instr_type;
                r_wb_pc         <= w_sel_pc;
                r_wb_result     <= w_sel_result;
                r_wb_rob_id     <= w_sel_rob_id;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt <= '0;
        end else if (bus.flush) begin
            r_wait_cnt <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (w_grant[i]) begin
                    r_wait_cnt[i] <= '0;
                end else if (w_stall[i] && (r_wait_cnt[i] != '1)) begin
                    r_wait_cnt[i] <= r_wait_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.grant         = w_grant;
    assign bus.req_stall     = w_stall;
    assign bus.wb_valid      = r_wb_valid;
    assign bus.wb_instr_type = r_wb_instr_type;
    assign bus.wb_pc         = r_wb_pc;
    assign bus.wb_result     = r_wb_result;
    assign bus.wb_rob_id     = r_wb_rob_id;
    assign bus.wait_cnt      = r_wait_cnt;
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single ROB writeback port among NUM_REQ execution pipes.
- Requester 0 is ALU, 1 is MEM (cache stage), 2 is MUL (last M stage).
- Each cycle it selects one valid requester by round-robin and registers its result toward the ROB.
- It asserts per-requester stall so losing pipes hold their stage registers.
- It keeps saturating per-requester wait counters for performance monitoring.

Parameters:
- NUM_REQ, 3: number of requesting pipes (2..8).
- WORD_SIZE, `WORD_SIZE: data/pc width.
- INSTR_TYPE_SZ, `INSTR_TYPE_SZ: instruction type field width.
- ROB_ENTRY_WIDTH, `ROB_ENTRY_WIDTH: ROB index width.
- WAIT_CNT_W, 8: wait counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request i has a result ready.
- req_instr_type  in  NUM_REQ*INSTR_TYPE_SZ  packed; slice i belongs to requester i.
- req_pc  in  NUM_REQ*WORD_SIZE  packed.
- req_result  in  NUM_REQ*WORD_SIZE  packed.
- req_rob_id  in  NUM_REQ*ROB_ENTRY_WIDTH  packed.
- rob_ready  in  1  ROB can accept a write this cycle.
- flush  in  1  pipeline flush (mispredict or exception).
- req_stall  out  NUM_REQ  combinational; requester i must hold its stage.
- grant  out  NUM_REQ  combinational one-hot winner; all zero if none.
- wb_valid  out  1  registered.
- wb_instr_type  out  INSTR_TYPE_SZ  registered.
- wb_pc  out  WORD_SIZE  registered.
- wb_result  out  WORD_SIZE  registered.
- wb_rob_id  out  ROB_ENTRY_WIDTH  registered.
- wait_cnt  out  NUM_REQ*WAIT_CNT_W  per-requester saturating wait cycles.

Behaviour:
- Reset (reset=0, async):
  - wb_valid=0, wb_instr_type/pc/result/rob_id=0.
  - rr_ptr=0, all wait_cnt=0.
  - Comb outputs with reset asserted: grant=0, req_stall=0.
- Arbitration (combinational):
  - Search starts at rr_ptr and proceeds upward, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
  - Arbitration is enabled only when rob_ready=1 and flush=0. Otherwise grant=0.
- Stall:
  - req_stall[i] = req_valid[i] & ~grant[i] & ~flush.
  - A non-valid requester is never stalled.
  - During flush no stalls are asserted, so pipes drain or clear themselves.
- Latency:
  - The winner's fields appear on wb_* at the next posedge with wb_valid=1. One cycle latency.
  - With no grant, wb_valid=0 next cycle; the wb_* data fields hold their previous values.
- Round-robin pointer:
  - After a grant to i, rr_ptr <= (i+1) mod NUM_REQ.
  - With no grant, rr_ptr is unchanged.
  - Wrap: a grant to NUM_REQ-1 sets rr_ptr to 0.
- Wait counters:
  - wait_cnt[i] increments when req_stall[i]=1 and saturates at 2^WAIT_CNT_W-1.
  - It clears to 0 on the cycle requester i is granted.
  - A cycle that is neither stalled nor granted leaves it unchanged.
- Flush:
  - Takes priority over everything.
  - Next cycle wb_valid=0, rr_ptr unchanged, wait_cnt all cleared.
  - A result granted in the previous cycle (already in wb_*) is also squashed: wb_valid goes 0 on the flush edge.
- rob_ready=0:
  - No grant; every valid requester is stalled.
  - wb_valid goes 0 on the next edge. The ROB consumes wb_* only when wb_valid=1.
- Simultaneous requests: at most one grant per cycle; all other valid requesters are stalled.
- Requester contract:
  - A stalled requester holds valid and data unchanged until granted or flushed.
  - Fairness is guaranteed: a continuously valid requester is granted within NUM_REQ cycles of rob_ready=1.
- Reset mid-operation: all state clears immediately; stalls drop asynchronously.

Decomposition:
- Shared defines package holds `WORD_SIZE, `INSTR_TYPE_SZ, `ROB_ENTRY_WIDTH, and the requester index constants `WB_REQ_ALU=0, `WB_REQ_MEM=1, `WB_REQ_MUL=2.
- One sub-module: rr_arbiter (NUM_REQ): request vector plus pointer in, one-hot grant and next pointer out, purely combinational.
- The top level holds the pointer register, the output register, and the counters.

Test Plan:
- Single ALU request, rob_id=5, result=0xDEADBEEF, rob_ready=1 -> grant=001, no stalls; next cycle wb_valid=1, wb_rob_id=5, wb_result=0xDEADBEEF.
- All three valid continuously from rr_ptr=0 -> grants 0,1,2,0 on consecutive cycles. req_stall is 110, 101, 011, 110. wait_cnt[2] reaches 2, then clears.
- MUL (i=2) and ALU valid with rr_ptr=2 -> MUL wins, rr_ptr wraps to 0; next cycle ALU wins.
- rob_ready=0 for 3 cycles with MEM valid -> grant=0, req_stall=010 for 3 cycles, wait_cnt[1]=3, wb_valid=0. rob_ready=1 -> MEM granted, wait_cnt[1]=0.
- Flush with wb_valid=1 and two requesters valid -> grant=0, req_stall=0, next cycle wb_valid=0, all wait_cnt=0, rr_ptr unchanged.
- Hold requester 0 stalled for 300 cycles (rob_ready=0), WAIT_CNT_W=8 -> wait_cnt[0] saturates at 255. Assert reset=0 mid-run -> wb_valid=0, counters 0 immediately without a clock edge.
